// File: rtl/div32by16_seq.sv
// Sequential restoring divider: 32-bit unsigned dividend / 16-bit unsigned divisor,
// one quotient bit per clock, with a start/busy/done handshake.
module div32by16_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_t;

  state_t      state_q, state_d;
  logic [16:0] p_q, p_d;
  logic [31:0] q_q, q_d;
  logic [15:0] dvsr_q, dvsr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        dz_q, dz_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] quot_q, quot_d;
  logic [15:0] rem_q, rem_d;
  logic        dbz_q, dbz_d;

  logic [16:0] p_shift;
  logic [16:0] p_sub;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    // 17-bit partial remainder keeps the shifted-in bit from overflowing the compare
    p_shift = {p_q[15:0], q_q[31]};
    p_sub   = p_shift - {1'b0, dvsr_q};

    unique case (state_q)
      StIdle: begin
        if (start) begin
          dvsr_d  = divisor;
          q_d     = dividend;
          p_d     = 17'd0;
          cnt_d   = 5'd0;
          busy_d  = 1'b1;
          dz_d    = (divisor == 16'd0);
          state_d = (divisor == 16'd0) ? StFin : StRun;
        end
      end
      StRun: begin
        if (p_shift >= {1'b0, dvsr_q}) begin
          p_d = p_sub;
          q_d = {q_q[30:0], 1'b1};
        end else begin
          p_d = p_shift;
          q_d = {q_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StFin;
        end
      end
      StFin: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
        if (dz_q) begin
          // Q still holds the untouched dividend on the divide-by-zero path
          quot_d = 32'hFFFF_FFFF;
          rem_d  = q_q[15:0];
          dbz_d  = 1'b1;
        end else begin
          quot_d = q_q;
          rem_d  = p_q[15:0];
          dbz_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      p_q     <= 17'd0;
      q_q     <= 32'd0;
      dvsr_q  <= 16'd0;
      cnt_q   <= 5'd0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= 32'd0;
      rem_q   <= 16'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32by16_seq.sv
// Directed bench for div32by16_seq: latency, results, ignored start, back-to-back,
// mid-operation reset and a short randomized multiply-back check.
module tb_div32by16_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int checks;
  int errors;

  div32by16_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for exactly one edge (E0); caller is 1 ns after an edge.
  task automatic issue(input logic [31:0] dvd, input logic [15:0] dvs);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    tick();
    start    = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
  endtask

  // Counts edges after E0 until done is seen; flags overlap of busy and done.
  task automatic wait_done(output int n);
    logic overlap;
    overlap = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
      if (busy && done) overlap = 1'b1;
    end
    check("busy_done_overlap", 64'(overlap), 64'd0);
    check("done_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    int n;
    logic [31:0] rq;
    logic [31:0] rdvd;
    logic [15:0] rdvs;
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 16'd0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_quot", 64'(quotient), 64'd0);
    check("rst_rem", 64'(remainder), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1000 / 7: done is sampled after E33, i.e. the 34th edge counting E0.
    issue(32'd1000, 16'd7);
    check("t1_busy_after_e0", 64'(busy), 64'd1);
    wait_done(n);
    check("t1_latency", 64'(n), 64'd33);
    check("t1_busy_in_done", 64'(busy), 64'd0);
    check("t1_quot", 64'(quotient), 64'd142);
    check("t1_rem", 64'(remainder), 64'd6);
    check("t1_dbz", 64'(div_by_zero), 64'd0);
    tick();
    check("t1_done_width", 64'(done), 64'd0);
    check("t1_quot_held", 64'(quotient), 64'd142);

    // Max operands, then dividend smaller than divisor.
    issue(32'hFFFF_FFFF, 16'hFFFF);
    repeat (5) tick();
    check("t2_quot_stable_midrun", 64'(quotient), 64'd142);
    wait_done(n);
    check("t2a_quot", 64'(quotient), 64'h0001_0001);
    check("t2a_rem", 64'(remainder), 64'd0);
    tick();
    issue(32'd3, 16'd10);
    wait_done(n);
    check("t2b_quot", 64'(quotient), 64'd0);
    check("t2b_rem", 64'(remainder), 64'd3);

    // Divide by zero.
    tick();
    issue(32'd5, 16'd0);
    wait_done(n);
    check("t3_latency", 64'(n), 64'd1);
    check("t3_dbz", 64'(div_by_zero), 64'd1);
    check("t3_quot", 64'(quotient), 64'hFFFF_FFFF);
    check("t3_rem", 64'(remainder), 64'd5);
    tick();
    check("t3_done_width", 64'(done), 64'd0);
    check("t3_dbz_held", 64'(div_by_zero), 64'd1);

    // Start mid-run is ignored; start in the done cycle is accepted.
    issue(32'd1000, 16'd7);
    repeat (10) tick();
    issue(32'd50, 16'd3);
    wait_done(n);
    check("t4_latency_unchanged", 64'(n), 64'd22);
    check("t4_quot", 64'(quotient), 64'd142);
    check("t4_rem", 64'(remainder), 64'd6);
    check("t4_dbz_cleared", 64'(div_by_zero), 64'd0);
    issue(32'd100, 16'd9);
    check("t4_b2b_busy", 64'(busy), 64'd1);
    check("t4_b2b_done_low", 64'(done), 64'd0);
    wait_done(n);
    check("t4_b2b_latency", 64'(n), 64'd33);
    check("t4_b2b_quot", 64'(quotient), 64'd11);
    check("t4_b2b_rem", 64'(remainder), 64'd1);

    // Reset during iteration 10 aborts with no done.
    tick();
    issue(32'd1000, 16'd7);
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_quot", 64'(quotient), 64'd0);
    check("t5_rst_rem", 64'(remainder), 64'd0);
    check("t5_rst_dbz", 64'(div_by_zero), 64'd0);
    tick();
    rst_n = 1'b1;
    n = 0;
    repeat (40) begin
      tick();
      if (done) n++;
    end
    check("t5_no_done_after_abort", 64'(n), 64'd0);
    issue(32'd100, 16'd9);
    wait_done(n);
    check("t5_quot", 64'(quotient), 64'd11);
    check("t5_rem", 64'(remainder), 64'd1);

    // Random operands checked by multiplying back.
    for (int i = 0; i < 20; i++) begin
      tick();
      rdvd = $urandom;
      rdvs = 16'($urandom_range(1, 65535));
      if (i == 0) rdvs = 16'd1;
      issue(rdvd, rdvs);
      wait_done(n);
      rq = quotient;
      check("rnd_mulback", 64'(rq) * 64'(rdvs) + 64'(remainder), 64'(rdvd));
      check("rnd_rem_lt_divisor", 64'(remainder < rdvs), 64'd1);
      check("rnd_quot", 64'(rq), 64'(rdvd / 32'(rdvs)));
      tick();
      check("rnd_done_width", 64'(done), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
